mem_store_buffer: RTL and testbench
===================================

// Module: mem_store_buffer
// PURPOSE
//  Posted-write store buffer between the CPU MEM stage and data memory.
//  MEM-stage SW operations enqueue {addr,data} and retire in one cycle.
//  Queued entries drain in order to the memory port over a req/ack handshake.
//  LW lookups are forwarded from the youngest matching queued entry, so loads never read stale memory.
// PARAMETERS
//  ADDR_W  10  word-address width (1024-word memory)
//  DATA_W  32  data word width
//  DEPTH   4   entries; must be a power of 2, >= 2
// PORTS
//  clk1       in   1       single clock, all state on posedge
//  rst_n      in   1       synchronous, active-low reset
//  st_valid   in   1       MEM stage presents a store
//  st_ready   out  1       buffer can accept a store this cycle
//  st_addr    in   ADDR_W  store word address
//  st_data    in   DATA_W  store data
//  ld_addr    in   ADDR_W  MEM-stage load address (combinational lookup)
//  ld_hit     out  1       ld_addr matches a valid queued entry
//  ld_data    out  DATA_W  data of youngest matching entry; 0 when !ld_hit
//  mem_req    out  1       write request to data memory
//  mem_addr   out  ADDR_W  head-entry address, stable while mem_req=1
//  mem_wdata  out  DATA_W  head-entry data, stable while mem_req=1
//  mem_ack    in   1       memory accepted the write this cycle
//  empty      out  1       no queued entries and no write outstanding
// BEHAVIOUR
//  - Interface: one clock (clk1); reset is synchronous and active-low (rst_n).
//  - Reset (rst_n=0 at posedge): wr_ptr=rd_ptr=0, count=0, FSM=IDLE, all entries invalid.
//    Outputs during and after reset: mem_req=0, empty=1, ld_hit=0.
//    st_ready is forced to 0 while rst_n=0.
//  - Reset mid-drain: queued entries are discarded and mem_req drops the cycle after the reset edge.
//    A write already acked by memory stands.
//  - Storage: circular array; count is 0..DEPTH; pointers have log2(DEPTH) bits and wrap modulo DEPTH.
//  - Push: st_valid & st_ready at posedge writes entry[wr_ptr] and advances wr_ptr.
//    The entry becomes visible to lookup and drain the next cycle.
//  - st_ready = rst_n & (count != DEPTH). It is combinational from registered count only.
//    A same-cycle pop does not open a slot at full.
//  - Drain FSM:
//    - IDLE: count>0 -> REQ.
//    - REQ: mem_req=1 and mem_addr/mem_wdata = entry[rd_ptr].
//      On mem_ack, pop (rd_ptr++, count--).
//      If count-after-pop > 0, stay in REQ and present the next entry the next cycle (back-to-back, no bubble).
//      Otherwise go to IDLE.
//    - mem_ack is ignored while mem_req=0.
//  - Simultaneous push+pop: count unchanged, both pointers advance.
//  - Lookup: compare ld_addr against all valid entries; the youngest (nearest wr_ptr) wins.
//    The head entry being acked this cycle still matches.
//    A store pushed this cycle is not matched until the next cycle.
//  - empty = (count==0) & (FSM==IDLE). The CPU waits on empty before asserting HALTED.
//  - Data is stored unmodified (no arithmetic); no write coalescing.
// STRUCTURE
//  - Shared package cpu_pkg: opcode and instruction-type constants (LW, SW, LOAD, STORE, ...) and ADDR_W/DATA_W defaults.
//  - Sub-module sb_fwd_match: combinational age-priority matcher.
//    Inputs: entry addr/data/valid vectors, rd_ptr, count, ld_addr.
//    Outputs: ld_hit, ld_data.
//  - Top level holds the storage array, pointers, count and the 2-state drain FSM.
// TESTING
//  1. Push addr 5 data 0xAAAA0001 with mem_ack held 1.
//     Next cycle mem_req=1 addr 5; the cycle after, empty=1. Memory word 5 = 0xAAAA0001.
//  2. mem_ack held 0; push 4 stores to addrs 1..4.
//     st_ready=0 after the 4th. A 5th st_valid is not accepted; count stays 4.
//  3. Push addr 7 =0x11, then addr 7 =0x22; ld_addr=7.
//     ld_hit=1, ld_data=0x22. ld_addr=8 -> ld_hit=0, ld_data=0.
//  4. At full with mem_ack=1 and st_valid=1: the store is rejected.
//     The next cycle st_ready=1 and a push+pop together leave count at 3.
//     Entries drain in FIFO order.
//  5. Push 6 stores (addrs 10..15) with mem_ack toggling 1/0.
//     Pointers wrap and all 6 writes reach memory in order, without loss or duplication.
//  6. rst_n=0 for 1 cycle while 3 entries are queued and mem_req=1.
//     Next cycle mem_req=0, empty=1, ld_hit=0. Only writes acked before reset reached memory.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode and instruction-class constants, default
// memory geometry, and the drain-state encoding used by the store buffer.
package cpu_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2b;

    typedef enum logic [1:0] {
        INSTR_ALU    = 2'd0,
        INSTR_LOAD   = 2'd1,
        INSTR_STORE  = 2'd2,
        INSTR_BRANCH = 2'd3
    } instr_type_e;

    typedef enum logic {
        SB_IDLE = 1'b0,
        SB_REQ  = 1'b1
    } sb_state_e;

    // Classify an opcode for the MEM stage (loads and stores touch the buffer)
    function automatic instr_type_e op_to_type(input logic [5:0] op);
        instr_type_e t;
        t = INSTR_ALU;
        if (op == OP_LW) t = INSTR_LOAD;
        if (op == OP_SW) t = INSTR_STORE;
        return t;
    endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Age-priority store-to-load forwarding matcher. Scans queued entries from
// the oldest (rd_ptr) toward the youngest, so the last match found wins.
module sb_fwd_match
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic [DEPTH-1:0][ADDR_W-1:0] entry_addr_i,
    input  logic [DEPTH-1:0][DATA_W-1:0] entry_data_i,
    input  logic [DEPTH-1:0]             entry_valid_i,
    input  logic [PTR_W-1:0]             rd_ptr_i,
    input  logic [CNT_W-1:0]             count_i,
    input  logic [ADDR_W-1:0]            ld_addr_i,
    output logic                         ld_hit_o,
    output logic [DATA_W-1:0]            ld_data_o
);

    logic [PTR_W-1:0] idx;

    // Walk oldest-to-youngest; later (younger) matches overwrite earlier ones
    always_comb begin
        ld_hit_o  = 1'b0;
        ld_data_o = '0;
        idx       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_i + PTR_W'(k);
            if ((CNT_W'(k) < count_i) && entry_valid_i[idx] &&
                (entry_addr_i[idx] == ld_addr_i)) begin
                ld_hit_o  = 1'b1;
                ld_data_o = entry_data_i[idx];
            end
        end
    end

endmodule

// File: rtl/mem_store_buffer.sv
// Posted-write store buffer between the MEM stage and data memory. Stores
// retire into a circular queue in one cycle, drain in order over req/ack,
// and loads are forwarded from the youngest matching queued entry.
module mem_store_buffer
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_hit,
    output logic [DATA_W-1:0] ld_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_q;
    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]             count_q, count_d;
    sb_state_e                    state_q;
    logic                         push, pop;

    // Ready depends only on registered occupancy; a same-cycle pop does not free a slot
    assign st_ready  = rst_n & (count_q != FULL_CNT);
    assign mem_req   = (state_q == SB_REQ);
    assign mem_addr  = addr_q[rd_ptr_q];
    assign mem_wdata = data_q[rd_ptr_q];
    assign empty     = (count_q == '0) & (state_q == SB_IDLE);

    // Next-state for pointers, occupancy and entry valid bits
    always_comb begin
        push     = st_valid & st_ready;
        pop      = (state_q == SB_REQ) & mem_ack;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        valid_d  = valid_q;
        if (pop)  valid_d[rd_ptr_q] = 1'b0;
        if (push) valid_d[wr_ptr_q] = 1'b1;
    end

    // Queue control state; reset discards every queued entry
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Entry payload storage; contents are meaningless unless the valid bit is set
    always_ff @(posedge clk1) begin
        if (push) begin
            addr_q[wr_ptr_q] <= st_addr;
            data_q[wr_ptr_q] <= st_data;
        end
    end

    // Drain FSM: stay in REQ back-to-back while entries remain after a pop
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_q <= SB_IDLE;
        end else begin
            case (state_q)
                SB_IDLE: if (count_q != '0) state_q <= SB_REQ;
                SB_REQ:  if (pop && (count_d == '0)) state_q <= SB_IDLE;
                default: state_q <= SB_IDLE;
            endcase
        end
    end

    sb_fwd_match #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_fwd (
        .entry_addr_i (addr_q),
        .entry_data_i (data_q),
        .entry_valid_i(valid_q),
        .rd_ptr_i     (rd_ptr_q),
        .count_i      (count_q),
        .ld_addr_i    (ld_addr),
        .ld_hit_o     (ld_hit),
        .ld_data_o    (ld_data)
    );

endmodule

// File: tb/tb_mem_store_buffer.sv
// Bench for mem_store_buffer: table-driven load-forwarding vectors, a
// scoreboard of accepted stores compared against the memory write stream,
// and hand-written sequences for full, wrap and mid-drain reset cases.
module tb_mem_store_buffer;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              clk1 = 1'b0;
    logic              rst_n;
    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_hit;
    logic [DATA_W-1:0] ld_data;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic              empty;

    always #10 clk1 = ~clk1;

    mem_store_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk1     (clk1),
        .rst_n    (rst_n),
        .st_valid (st_valid),
        .st_ready (st_ready),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .ld_addr  (ld_addr),
        .ld_hit   (ld_hit),
        .ld_data  (ld_data),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .empty    (empty)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    typedef struct {
        logic [ADDR_W-1:0] la;
        logic              hit;
        logic [DATA_W-1:0] d;
        string             name;
    } ld_vec_t;

    wr_t         exp_q[$];
    ld_vec_t     ld_tbl[6];
    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    logic [DATA_W-1:0] mem_model [0:1023];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // One clock: record an accepted store, check a completed write, then advance
    task automatic step_acc(output bit acc);
        bit  in_rst;
        wr_t e;
        #1;
        acc    = rst_n && st_valid && st_ready;
        in_rst = !rst_n;
        if (acc) begin
            e = {st_addr, st_data};
            exp_q.push_back(e);
        end
        if (mem_req && mem_ack) begin
            wr_cnt++;
            mem_model[mem_addr] = mem_wdata;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_write actual=addr 0x%0h required=no write", mem_addr);
            end else begin
                e = exp_q.pop_front();
                chk("sb_addr", 32'(mem_addr), 32'(e.addr));
                chk("sb_data", mem_wdata, e.data);
            end
        end
        @(posedge clk1);
        if (in_rst) exp_q.delete();
        @(negedge clk1);
    endtask

    task automatic step();
        bit dummy;
        step_acc(dummy);
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        step();
        st_valid = 1'b0;
    endtask

    task automatic drain(input bit toggle, input string name);
        int n = 0;
        while (!empty && n < 50) begin
            if (toggle) mem_ack = ~mem_ack;
            step();
            n++;
        end
        chk({name, "_drained"}, 32'(empty), 32'd1);
        chk({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_ld(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            ld_addr = ld_tbl[i].la;
            #1;
            chk({ld_tbl[i].name, "_hit"},  32'(ld_hit), 32'(ld_tbl[i].hit));
            chk({ld_tbl[i].name, "_data"}, ld_data, ld_tbl[i].d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  base;
        int  i;
        int  guard;
        bit  acc;

        ld_tbl[0] = '{10'd1, 1'b1, 32'h0000_0101, "ld_full_a1"};
        ld_tbl[1] = '{10'd4, 1'b1, 32'h0000_0104, "ld_full_a4"};
        ld_tbl[2] = '{10'd3, 1'b1, 32'h0000_0103, "ld_full_a3"};
        ld_tbl[3] = '{10'd9, 1'b0, 32'h0000_0000, "ld_full_a9"};
        ld_tbl[4] = '{10'd7, 1'b1, 32'h0000_0022, "ld_young_a7"};
        ld_tbl[5] = '{10'd8, 1'b0, 32'h0000_0000, "ld_miss_a8"};
        for (int k = 0; k < 1024; k++) mem_model[k] = '0;

        rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_addr = '0; mem_ack = 1'b0;

        // Reset
        #1;
        chk("rst_st_ready_low", 32'(st_ready), 32'd0);
        @(negedge clk1);
        step();
        step();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ld_hit", 32'(ld_hit), 32'd0);
        chk("rst_st_ready_in_reset", 32'(st_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_st_ready_after", 32'(st_ready), 32'd1);
        @(negedge clk1);

        // Single store with ack held high
        base = wr_cnt;
        mem_ack = 1'b1;
        push(10'd5, 32'hAAAA_0001);
        chk("t1_not_empty", 32'(empty), 32'd0);
        step();
        chk("t1_mem_req", 32'(mem_req), 32'd1);
        chk("t1_mem_addr", 32'(mem_addr), 32'd5);
        chk("t1_mem_wdata", mem_wdata, 32'hAAAA_0001);
        step();
        chk("t1_empty", 32'(empty), 32'd1);
        chk("t1_mem5", mem_model[5], 32'hAAAA_0001);
        chk("t1_writes", 32'(wr_cnt - base), 32'd1);

        // Fill to full with ack low; a fifth store is refused
        base = wr_cnt;
        mem_ack = 1'b0;
        for (int k = 1; k <= 4; k++) push(10'(k), 32'h100 + 32'(k));
        chk("t2_full_st_ready", 32'(st_ready), 32'd0);
        chk("t2_mem_req", 32'(mem_req), 32'd1);
        run_ld(0, 4);
        st_valid = 1'b1; st_addr = 10'd9; st_data = 32'h109;
        step();
        chk("t2_still_full", 32'(st_ready), 32'd0);
        ld_addr = 10'd9;
        #1;
        chk("t2_fifth_not_stored", 32'(ld_hit), 32'd0);

        // Full with ack: store refused, then push+pop keeps occupancy
        st_valid = 1'b1; st_addr = 10'd20; st_data = 32'h200; mem_ack = 1'b1;
        chk("t4_full_refuse", 32'(st_ready), 32'd0);
        step();
        chk("t4_ready_after_pop", 32'(st_ready), 32'd1);
        chk("t4_b2b_addr", 32'(mem_addr), 32'd2);
        step();
        st_valid = 1'b0;
        chk("t4_pushpop_ready", 32'(st_ready), 32'd1);
        chk("t4_b2b_addr2", 32'(mem_addr), 32'd3);
        ld_addr = 10'd20;
        #1;
        chk("t4_new_visible", 32'(ld_hit), 32'd1);
        drain(1'b0, "t4");
        chk("t4_writes", 32'(wr_cnt - base), 32'd5);
        chk("t4_mem20", mem_model[20], 32'h200);

        // Youngest match wins; a store in flight this cycle is not yet visible
        base = wr_cnt;
        mem_ack = 1'b0;
        push(10'd7, 32'h11);
        push(10'd7, 32'h22);
        run_ld(4, 6);
        st_valid = 1'b1; st_addr = 10'd8; st_data = 32'h33; ld_addr = 10'd8;
        #1;
        chk("t3_same_cycle_miss", 32'(ld_hit), 32'd0);
        step();
        st_valid = 1'b0;
        chk("t3_next_cycle_hit", 32'(ld_hit), 32'd1);
        chk("t3_next_cycle_data", ld_data, 32'h33);
        mem_ack = 1'b1;
        drain(1'b0, "t3");
        ld_addr = 10'd7;
        #1;
        chk("t3_drained_miss", 32'(ld_hit), 32'd0);
        chk("t3_mem7", mem_model[7], 32'h22);
        chk("t3_writes", 32'(wr_cnt - base), 32'd3);

        // Six stores with toggling ack: pointers wrap, order preserved
        base = wr_cnt;
        mem_ack = 1'b0;
        i = 0;
        guard = 0;
        while (i < 6 && guard < 100) begin
            st_valid = 1'b1;
            st_addr  = 10'(10 + i);
            st_data  = 32'h5000 + 32'(i);
            mem_ack  = ~mem_ack;
            step_acc(acc);
            if (acc) i++;
            guard++;
        end
        st_valid = 1'b0;
        chk("t5_all_accepted", 32'(i), 32'd6);
        drain(1'b1, "t5");
        chk("t5_writes", 32'(wr_cnt - base), 32'd6);
        for (int k = 0; k < 6; k++)
            chk("t5_mem", mem_model[10 + k], 32'h5000 + 32'(k));

        // Reset mid-drain: only the acked write lands
        base = wr_cnt;
        mem_ack = 1'b0;
        for (int k = 0; k < 4; k++) push(10'(30 + k), 32'h600 + 32'(k));
        chk("t6_req_before", 32'(mem_req), 32'd1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("t6_req_three_left", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_ready_in_reset", 32'(st_ready), 32'd0);
        step();
        rst_n = 1'b1;
        ld_addr = 10'd31;
        #1;
        chk("t6_mem_req", 32'(mem_req), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);
        chk("t6_ld_hit", 32'(ld_hit), 32'd0);
        chk("t6_ld_data", ld_data, 32'd0);
        mem_ack = 1'b1;
        step();
        step();
        step();
        chk("t6_writes", 32'(wr_cnt - base), 32'd1);
        chk("t6_mem30", mem_model[30], 32'h600);
        chk("t6_mem31", mem_model[31], 32'd0);
        chk("t6_still_empty", 32'(empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
